// File: rtl/dsp_div_32_16.sv
// Sequential signed restoring divider: 32-bit dividend by 16-bit divisor, one quotient bit per cycle.
// Produces a saturated 16-bit quotient and a remainder whose sign follows the dividend.
module dsp_div_32_16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] X,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [15:0] R,
  output logic        ovf,
  output logic        dbz
);

  localparam int unsigned XW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned RW = BW + 1;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_n;
  logic [XW-1:0]   absx;
  logic [RW-1:0]   absb;
  logic [XW-1:0]   quot;
  logic [RW-1:0]   rem;
  logic [CW-1:0]   cnt;
  logic            sign_q, sign_r, dbz_r;

  logic [RW-1:0]   bx, rem_sh, rem_sub;
  logic            take;
  logic            fix_ovf, fix_sat;
  logic [BW-1:0]   fix_q, fix_r;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CALC;
      CALC:    if (cnt == CW'(XW - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One restoring step; remainder magnitude stays below |B| so 17 bits suffice
  always_comb begin
    bx      = {B[BW-1], B};
    rem_sh  = RW'({rem, absx[XW-1]});
    take    = (rem_sh >= absb);
    rem_sub = rem_sh - absb;
  end

  // Sign application and saturation for the result registers
  always_comb begin
    fix_ovf = 1'b0;
    if (!dbz_r) begin
      if (sign_q) fix_ovf = (quot > XW'(32768));
      else        fix_ovf = (quot > XW'(32767));
    end
    fix_sat = fix_ovf | dbz_r;
    fix_q   = sign_q ? BW'(-quot[BW-1:0]) : quot[BW-1:0];
    fix_r   = sign_r ? BW'(-rem[BW-1:0]) : rem[BW-1:0];
    if (fix_sat) begin
      fix_q = sign_q ? 16'h8000 : 16'h7FFF;
      fix_r = '0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= '0;
      R         <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      absx      <= '0;
      absb      <= '0;
      quot      <= '0;
      rem       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            absx   <= X[XW-1] ? XW'(-X) : X;
            absb   <= B[BW-1] ? RW'(-bx) : bx;
            dbz_r  <= (B == '0);
            sign_q <= (B == '0) ? X[XW-1] : (X[XW-1] ^ B[BW-1]);
            sign_r <= X[XW-1];
            quot   <= '0;
            rem    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          absx <= {absx[XW-2:0], 1'b0};
          quot <= {quot[XW-2:0], take};
          rem  <= take ? rem_sub : rem_sh;
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          Q   <= fix_q;
          R   <= fix_r;
          ovf <= fix_ovf;
          dbz <= dbz_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_div_32_16.sv
// Directed and randomised checks of dsp_div_32_16: values, saturation, divide-by-zero,
// fixed latency, backpressure and mid-operation reset.
module tb_dsp_div_32_16;

  logic        clock = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] X;
  logic [15:0] B;
  logic        in_ready, out_valid, ovf, dbz;
  logic [15:0] Q, R;

  int n_checks = 0;
  int n_fail   = 0;

  // Handshake at edge t, out_valid visible in cycle t+34: first seen after the 33rd following edge.
  localparam int EXP_LAT = 33;

  always #5 clock = ~clock;

  dsp_div_32_16 dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .ovf(ovf), .dbz(dbz)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  // Issue one operation with out_ready high; lat is -1 if out_valid never arrived
  task automatic run_op(input logic [31:0] x, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic ov, output logic dz, output int lat);
    int w;
    lat = -1; q = '0; r = '0; ov = 1'b0; dz = 1'b0; w = 0;
    @(negedge clock);
    while (!in_ready && w < 50) begin @(negedge clock); w++; end
    X = x; B = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    for (int i = 1; i <= EXP_LAT + 20; i++) begin
      @(posedge clock); #1;
      if (out_valid) begin lat = i; break; end
    end
    if (lat >= 0) begin
      q = Q; r = R; ov = ovf; dz = dbz;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; B = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if ({Q, R, ovf, dbz} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs: got Q=%h R=%h ovf=%b dbz=%b want all 0", Q, R, ovf, dbz);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  // Shared body for directed tables: x, b -> expected q, r, ovf, dbz
  task automatic test_vectors(input string name, input logic [31:0] tx[], input logic [15:0] tb[],
                              input logic [15:0] tq[], input logic [15:0] tr[],
                              input logic to[], input logic tz[]);
    logic [15:0] q, r; logic ov, dz; int lat;
    for (int i = 0; i < tx.size(); i++) begin
      run_op(tx[i], tb[i], q, r, ov, dz, lat);
      n_checks++;
      if (q !== tq[i]) begin n_fail++; $display("FAIL %s_q[%0d]: got %h want %h", name, i, q, tq[i]); end
      n_checks++;
      if (r !== tr[i]) begin n_fail++; $display("FAIL %s_r[%0d]: got %h want %h", name, i, r, tr[i]); end
      n_checks++;
      if ({ov, dz} !== {to[i], tz[i]}) begin
        n_fail++; $display("FAIL %s_flags[%0d]: got ovf=%b dbz=%b want ovf=%b dbz=%b", name, i, ov, dz, to[i], tz[i]);
      end
      n_checks++;
      if (lat != EXP_LAT) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, EXP_LAT); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] tx[] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_5BF0, 32'hFFFF_FF9C};
    logic [15:0] tb[] = '{16'h0007, 16'h0007, 16'hFFF9, 16'hFFF9, 16'hFFF9};
    logic [15:0] tq[] = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h1770, 16'h000E};
    logic [15:0] tr[] = '{16'h0002, 16'hFFFE, 16'h0002, 16'h0000, 16'hFFFE};
    logic        to[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        tz[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    test_vectors("basic", tx, tb, tq, tr, to, tz);
  endtask

  task automatic test_boundaries();
    logic [31:0] tx[] = '{32'hFFFF_8000, 32'h0000_8000, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'hFFFF_7FFF};
    logic [15:0] tb[] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h8000, 16'h0001};
    logic [15:0] tq[] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    logic [15:0] tr[] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        to[] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        tz[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    test_vectors("bound", tx, tb, tq, tr, to, tz);
  endtask

  task automatic test_dbz();
    logic [31:0] tx[] = '{32'd5, 32'hFFFF_FFFB, 32'd0};
    logic [15:0] tb[] = '{16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tq[] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] tr[] = '{16'h0000, 16'h0000, 16'h0000};
    logic        to[] = '{1'b0, 1'b0, 1'b0};
    logic        tz[] = '{1'b1, 1'b1, 1'b1};
    test_vectors("dbz", tx, tb, tq, tr, to, tz);
  endtask

  // X = A*B must give back Q=A, R=0
  task automatic test_roundtrip();
    logic [15:0] a, b, q, r; logic ov, dz; int lat; longint p; logic [31:0] x;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (b == 16'd0) b = 16'd1;
      p = longint'($signed(a)) * longint'($signed(b));
      x = p[31:0];
      run_op(x, b, q, r, ov, dz, lat);
      n_checks++;
      if ({q, r, ov, dz, lat} !== {a, 16'h0000, 2'b00, EXP_LAT}) begin
        n_fail++;
        $display("FAIL roundtrip[%0d] x=%h b=%h: got q=%h r=%h ovf=%b dbz=%b lat=%0d want q=%h r=0 ovf=0 dbz=0 lat=%0d",
                 i, x, b, q, r, ov, dz, lat, a, EXP_LAT);
      end
    end
  endtask

  // Random operands against a truncating long-integer model
  task automatic test_random_identity();
    logic [31:0] x; logic signed [31:0] xs; logic [15:0] b, q, r, eq; logic ov, dz, eov; int lat;
    longint xl, bl, qt;
    for (int i = 0; i < 300; i++) begin
      xs = $signed(32'($urandom));
      xs = xs >>> $urandom_range(0, 20);
      x  = xs;
      b  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(1, 300));
      if (b == 16'd0) b = 16'd3;
      xl = longint'($signed(x)); bl = longint'($signed(b)); qt = xl / bl;
      eov = (qt > 32767) || (qt < -32768);
      eq  = eov ? ((qt > 0) ? 16'h7FFF : 16'h8000) : qt[15:0];
      run_op(x, b, q, r, ov, dz, lat);
      n_checks++;
      if ({ov, dz, q} !== {eov, 1'b0, eq}) begin
        n_fail++; $display("FAIL rand_q[%0d] x=%h b=%h: got q=%h ovf=%b dbz=%b want q=%h ovf=%b dbz=0", i, x, b, q, ov, dz, eq, eov);
      end
      n_checks++;
      if (!eov && (longint'($signed(q)) * bl + longint'($signed(r)) != xl)) begin
        n_fail++; $display("FAIL rand_identity[%0d] x=%h b=%h: got q=%h r=%h want q*b+r=x", i, x, b, q, r);
      end else if (eov && r !== 16'h0000) begin
        n_fail++; $display("FAIL rand_ovf_r[%0d]: got %h want 0000", i, r);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, w;
    lat = -1; w = 0;
    @(negedge clock);
    while (!in_ready && w < 50) begin @(negedge clock); w++; end
    X = 32'd1000; B = 16'hFFFD; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1 in_valid = 1'b0;
    for (int i = 1; i <= EXP_LAT + 20; i++) begin
      @(posedge clock); #1;
      if (out_valid) begin lat = i; break; end
    end
    n_checks++;
    if (lat != EXP_LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, EXP_LAT); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock); in_valid = k[0]; X = 32'd7; B = 16'd1;
      @(posedge clock); #1;
      n_checks++;
      if ({out_valid, in_ready, Q, R, ovf, dbz} !== {2'b10, 16'hFEB3, 16'h0001, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b Q=%h R=%h ovf=%b dbz=%b want 1 0 FEB3 0001 0 0",
                 k, out_valid, in_ready, Q, R, ovf, dbz);
      end
    end
    @(negedge clock); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clock); #1;
    n_checks++;
    if ({out_valid, Q, R} !== {1'b0, 16'hFEB3, 16'h0001}) begin
      n_fail++; $display("FAIL bp_after: got out_valid=%b Q=%h R=%h want 0 FEB3 0001", out_valid, Q, R);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [15:0] q, r; logic ov, dz; int lat; logic seen;
    @(negedge clock);
    X = 32'd100; B = 16'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({in_ready, out_valid, Q, R, ovf, dbz} !== {2'b10, 34'd0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got in_ready=%b out_valid=%b Q=%h R=%h ovf=%b dbz=%b want 1 0 0 0 0 0",
               in_ready, out_valid, Q, R, ovf, dbz);
    end
    @(negedge clock); reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clock); #1; if (out_valid) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_valid: got out_valid seen=%b want 0", seen); end
    run_op(32'd100, 16'd7, q, r, ov, dz, lat);
    n_checks++;
    if ({q, r, ov, dz} !== {16'h000E, 16'h0002, 2'b00}) begin
      n_fail++; $display("FAIL midreset_recover: got q=%h r=%h ovf=%b dbz=%b want 000E 0002 0 0", q, r, ov, dz);
    end
    n_checks++;
    if (lat != EXP_LAT) begin n_fail++; $display("FAIL midreset_latency: got %0d want %0d", lat, EXP_LAT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_dbz();
    test_backpressure();
    test_reset_mid_calc();
    test_roundtrip();
    test_random_identity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
